// File: rtl/lsu_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_controller_if
//  Description : EX-side request, data-memory, UART and writeback signals of
//                the load/store unit, with LSU (master) and environment views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lsu_controller_if;
    logic        flush;
    logic        ex_valid;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic [31:0] mem_rdata;
    logic        uart_tx_ready;

    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] ram_address;
    logic [31:0] mem_wdata;
    logic [2:0]  store_type;
    logic [2:0]  load_type;
    logic        send_to_uart;
    logic        uart_tx_valid;
    logic [7:0]  uart_tx_data;
    logic        lsu_stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;
    logic [31:0] fault_addr;

    modport master (
        input  flush, ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_addr,
               ex_store_data, ex_rd, mem_rdata, uart_tx_ready,
        output mem_read_en, mem_write_en, ram_address, mem_wdata, store_type,
               load_type, send_to_uart, uart_tx_valid, uart_tx_data, lsu_stall,
               wb_valid, wb_rd, wb_data, fault, fault_addr
    );

    modport slave (
        output flush, ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_addr,
               ex_store_data, ex_rd, mem_rdata, uart_tx_ready,
        input  mem_read_en, mem_write_en, ram_address, mem_wdata, store_type,
               load_type, send_to_uart, uart_tx_valid, uart_tx_data, lsu_stall,
               wb_valid, wb_rd, wb_data, fault, fault_addr
    );
endinterface
`default_nettype wire

// File: rtl/lsu_controller.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_controller
//  Description : MEM-stage load/store unit: alignment/legality checks, RAM
//                strobes with load extraction, UART store handshake, stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_controller #(
    parameter logic [31:0] UART_BASE = 32'h1000_0000
) (
    input  logic             clk,
    input  logic             reset,
    lsu_controller_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_UART  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] c_LOAD_TYPE_WORD = 3'b010;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [2:0]  r_store_type;
    logic [4:0]  r_rd;
    logic        r_is_load;
    logic        r_send_uart;
    logic        r_mem_read_en;
    logic        r_mem_write_en;
    logic        r_uart_valid;
    logic        r_wb_valid;
    logic [31:0] r_wb_data;
    logic        r_fault;
    logic [31:0] r_fault_addr;

    logic        w_accept;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_uart_space;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign w_accept     = (r_state == S_IDLE) && bus.ex_valid &&
                          (bus.ex_is_load || bus.ex_is_store) && !bus.flush;
    assign w_illegal    = bus.ex_is_load ?
                          ((bus.ex_funct3 == 3'b011) || (bus.ex_funct3 == 3'b110) ||
                           (bus.ex_funct3 == 3'b111)) :
                          (bus.ex_funct3 >= 3'b011);
    assign w_misaligned = ((bus.ex_funct3[1:0] == 2'b01) && bus.ex_addr[0]) ||
                          ((bus.ex_funct3[1:0] == 2'b10) && (bus.ex_addr[1:0] != 2'b00));
    assign w_uart_space = (bus.ex_addr >= UART_BASE);

    // Lane selection uses the latched address; memory returns the whole word.
    always_comb begin
        w_byte      = bus.mem_rdata[7:0];
        w_half      = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        w_load_data = bus.mem_rdata;
        case (r_addr[1:0])
            2'b00:   w_byte = bus.mem_rdata[7:0];
            2'b01:   w_byte = bus.mem_rdata[15:8];
            2'b10:   w_byte = bus.mem_rdata[23:16];
            default: w_byte = bus.mem_rdata[31:24];
        endcase
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_funct3       <= '0;
            r_store_type   <= '0;
            r_rd           <= '0;
            r_is_load      <= 1'b0;
            r_send_uart    <= 1'b0;
            r_mem_read_en  <= 1'b0;
            r_mem_write_en <= 1'b0;
            r_uart_valid   <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_wb_data      <= '0;
            r_fault        <= 1'b0;
            r_fault_addr   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr       <= bus.ex_addr;
                        r_wdata      <= bus.ex_store_data;
                        r_funct3     <= bus.ex_funct3;
                        r_rd         <= bus.ex_rd;
                        r_is_load    <= bus.ex_is_load;
                        r_store_type <= bus.ex_is_load ? 3'b000 : bus.ex_funct3;
                        r_send_uart  <= w_uart_space;
                        if (w_illegal || w_misaligned) begin
                            r_fault      <= 1'b1;
                            r_fault_addr <= bus.ex_addr;
                            r_state      <= S_DONE;
                        end else if (w_uart_space && !bus.ex_is_load) begin
                            r_uart_valid <= 1'b1;
                            r_state      <= S_UART;
                        end else if (w_uart_space) begin
                            // UART space has no readable registers: loads return zero.
                            r_wb_valid <= 1'b1;
                            r_wb_data  <= '0;
                            r_state    <= S_DONE;
                        end else begin
                            r_mem_read_en  <= bus.ex_is_load;
                            r_mem_write_en <= !bus.ex_is_load;
                            r_state        <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_mem_read_en  <= 1'b0;
                    r_mem_write_en <= 1'b0;
                    r_state        <= r_is_load ? S_WAIT : S_DONE;
                end
                S_WAIT: begin
                    r_wb_data  <= w_load_data;
                    r_wb_valid <= !bus.flush;
                    r_state    <= S_DONE;
                end
                S_UART: begin
                    if (bus.uart_tx_ready) begin
                        r_uart_valid <= 1'b0;
                        r_state      <= S_DONE;
                    end else if (bus.flush) begin
                        // Byte not yet taken: drop it and forget the op entirely.
                        r_uart_valid <= 1'b0;
                        r_send_uart  <= 1'b0;
                        r_addr       <= '0;
                        r_wdata      <= '0;
                        r_store_type <= '0;
                        r_state      <= S_IDLE;
                    end
                end
                S_DONE: begin
                    r_wb_valid <= 1'b0;
                    r_fault    <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_read_en   = r_mem_read_en;
    assign bus.mem_write_en  = r_mem_write_en;
    assign bus.ram_address   = r_addr;
    assign bus.mem_wdata     = r_wdata;
    assign bus.store_type    = r_store_type;
    assign bus.load_type     = c_LOAD_TYPE_WORD;
    assign bus.send_to_uart  = r_send_uart;
    assign bus.uart_tx_valid = r_uart_valid;
    assign bus.uart_tx_data  = r_wdata[7:0];
    assign bus.lsu_stall     = w_accept || (r_state == S_ISSUE) ||
                               (r_state == S_WAIT) || (r_state == S_UART);
    assign bus.wb_valid      = r_wb_valid;
    assign bus.wb_rd         = r_rd;
    assign bus.wb_data       = r_wb_data;
    assign bus.fault         = r_fault;
    assign bus.fault_addr    = r_fault_addr;

endmodule
`default_nettype wire
